alu_issue_stage: RTL

- Producer side of the ALU operation interface: decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code and selects operands.
- Drives the combinational ALU from a registered EX stage, captures ALUResult into an output stage and resolves branch outcome.
- Sits between the ID/EX boundary and writeback/branch logic; valid/ready handshake on both sides, flush for mispredicted paths.

---
 rtl/alu_issue_stage.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Producer side of the ALU operation interface. Decodes
//             ALUOp/Funct3/Funct7 into the ALU Operation code and selects
//             operands into a registered EX stage. The EX stage drives an
//             external combinational ALU. The ALU result is captured into a
//             registered output stage together with the branch outcome and
//             the illegal-decode flag.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             in_valid / in_ready    - upstream handshake
//             ALUOp, Funct3, Funct7  - decode inputs
//             ALUSrc, RegData1/2, Imm- operand sources
//             flush                  - kill EX-stage and same-cycle input
//             SrcA, SrcB, Operation  - registered ALU inputs
//             ALUResult              - combinational ALU output
//             out_valid / out_ready  - downstream handshake
//             Result, BranchTaken, IllegalOp - registered output stage
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    RegData1,
    input  logic [DATA_WIDTH-1:0]    RegData2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     BranchTaken,
    output logic                     IllegalOp
);

    // ALU operation encodings
    localparam logic [OPCODE_LENGTH-1:0] c_OP_AND  = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SUB  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_OR   = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_XOR  = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLL  = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRL  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRA  = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BEQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLT  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLTU = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BNE  = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BLT  = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BGE  = OPCODE_LENGTH'(4'b1101);

    localparam logic [1:0] c_ALUOP_MEM    = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] c_ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [OPCODE_LENGTH-1:0] w_op;
    logic                     w_illegal;
    logic                     w_branch;
    logic                     w_f7_zero;
    logic                     w_f7_alt;
    logic                     w_rtype;

    assign w_f7_zero = (Funct7 == c_F7_ZERO);
    assign w_f7_alt  = (Funct7 == c_F7_ALT);
    assign w_rtype   = (ALUOp == c_ALUOP_RTYPE);

    always_comb begin
        w_op      = c_OP_AND;
        w_illegal = 1'b0;
        w_branch  = 1'b0;
        case (ALUOp)
            c_ALUOP_MEM: w_op = c_OP_ADD;
            c_ALUOP_BRANCH: begin
                w_branch = 1'b1;
                case (Funct3)
                    3'b000:  w_op = c_OP_BEQ;
                    3'b001:  w_op = c_OP_BNE;
                    3'b100:  w_op = c_OP_BLT;
                    3'b101:  w_op = c_OP_BGE;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_ALUOP_RTYPE, c_ALUOP_ITYPE: begin
                case (Funct3)
                    3'b000: begin
                        // I-type ADDI ignores imm[11:5]; R-type picks ADD/SUB.
                        if (!w_rtype || w_f7_zero) begin
                            w_op = c_OP_ADD;
                        end else if (w_f7_alt) begin
                            w_op = c_OP_SUB;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b001: begin
                        w_op      = c_OP_SLL;
                        w_illegal = !w_f7_zero;
                    end
                    3'b101: begin
                        if (w_f7_zero) begin
                            w_op = c_OP_SRL;
                        end else if (w_f7_alt) begin
                            w_op = c_OP_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b010: begin
                        w_op      = c_OP_SLT;
                        w_illegal = w_rtype && !w_f7_zero;
                    end
                    3'b011: begin
                        w_op      = c_OP_SLTU;
                        w_illegal = w_rtype && !w_f7_zero;
                    end
                    3'b100: begin
                        w_op      = c_OP_XOR;
                        w_illegal = w_rtype && !w_f7_zero;
                    end
                    3'b110: begin
                        w_op      = c_OP_OR;
                        w_illegal = w_rtype && !w_f7_zero;
                    end
                    default: begin
                        w_op      = c_OP_AND;
                        w_illegal = w_rtype && !w_f7_zero;
                    end
                endcase
            end
            default: w_op = c_OP_ADD;
        endcase
        // An illegal instruction still flows through as a harmless AND and
        // must never report a taken branch.
        if (w_illegal) begin
            w_op     = c_OP_AND;
            w_branch = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic                     r_ex_valid;
    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic                     r_ex_branch;
    logic                     r_ex_illegal;

    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_result;
    logic                     r_branch_taken;
    logic                     r_illegal;

    logic                     w_out_accept;
    logic                     w_ex_adv;
    logic                     w_accept;

    assign w_out_accept = !r_out_valid || out_ready;
    // A flushed EX instruction is dropped, never handed to the output stage.
    assign w_ex_adv     = r_ex_valid && w_out_accept && !flush;
    assign in_ready     = !flush && (!r_ex_valid || w_out_accept);
    assign w_accept     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // EX stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid   <= 1'b0;
            r_srca       <= '0;
            r_srcb       <= '0;
            r_op         <= c_OP_AND;
            r_ex_branch  <= 1'b0;
            r_ex_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid <= 1'b1;
            end else if (w_ex_adv) begin
                r_ex_valid <= 1'b0;
            end
            // Payload only moves on accept so ALU inputs stay stable while stalled.
            if (w_accept) begin
                r_srca       <= RegData1;
                r_srcb       <= ALUSrc ? Imm : RegData2;
                r_op         <= w_op;
                r_ex_branch  <= w_branch;
                r_ex_illegal <= w_illegal;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
        end else if (w_ex_adv) begin
            r_out_valid    <= 1'b1;
            r_result       <= ALUResult;
            r_branch_taken <= r_ex_branch && ALUResult[0];
            r_illegal      <= r_ex_illegal;
        end else if (out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign SrcA        = r_srca;
    assign SrcB        = r_srcb;
    assign Operation   = r_op;
    assign out_valid   = r_out_valid;
    assign Result      = r_result;
    assign BranchTaken = r_branch_taken;
    assign IllegalOp   = r_illegal;

endmodule
`default_nettype wire
